// File: rtl/corelet_pkg.sv
// Shared types and inst-word layout for the corelet instruction sequencer.
package corelet_pkg;

    localparam int unsigned INST_W        = 34;
    localparam int unsigned KLOAD         = 0;
    localparam int unsigned EXEC          = 1;
    localparam int unsigned L0_WR         = 2;
    localparam int unsigned L0_RD         = 3;
    localparam int unsigned OFIFO_RD      = 6;
    localparam int unsigned XMEM_ADDR_LSB = 7;
    localparam int unsigned XMEM_ADDR_MSB = 17;
    localparam int unsigned XMEM_CEN      = 18;
    localparam int unsigned XMEM_WEN      = 19;
    localparam int unsigned PMEM_ADDR_LSB = 20;
    localparam int unsigned PMEM_ADDR_MSB = 30;
    localparam int unsigned PMEM_CEN      = 31;
    localparam int unsigned PMEM_WEN      = 32;
    localparam int unsigned ACC_ECHO      = 33;

    // Idle/reset word as the corelet expects it; busy states also park xmem CEN high.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_8008_0000;
    localparam logic [INST_W-1:0] INST_NOP  = INST_IDLE | (INST_W'(1) << XMEM_CEN);

    typedef enum logic [3:0] {
        S_IDLE,
        S_KWR,
        S_KLD,
        S_KWAIT,
        S_XWR,
        S_EXEC,
        S_DRAIN,
        S_READ,
        S_DONE
    } state_t;

endpackage

// File: rtl/corelet_ctrl_if.sv
// Host handshake plus corelet/SRAM instruction bus of the sequencer.
interface corelet_ctrl_if #(
    parameter int unsigned len_bw  = 6,
    parameter int unsigned addr_bw = 11
);
    import corelet_pkg::*;

    logic               start;
    logic               acc;
    logic [len_bw-1:0]  len;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] x_base;
    logic [addr_bw-1:0] p_base;
    logic               ofifo_valid;
    logic [INST_W-1:0]  inst;
    logic               xw_mode;
    logic               sfp_reset;
    logic               busy;
    logic               done;

    modport master (
        input  start, acc, len, w_base, x_base, p_base, ofifo_valid,
        output inst, xw_mode, sfp_reset, busy, done
    );

    modport slave (
        output start, acc, len, w_base, x_base, p_base, ofifo_valid,
        input  inst, xw_mode, sfp_reset, busy, done
    );

endinterface

// File: rtl/corelet_ctrl_phase_counter.sv
// Loadable saturating down-counter timing each sequencer phase.
module phase_counter #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_nxt_c,
    output logic             tc_c
);
    logic [WIDTH-1:0] count;

    always_comb begin
        count_nxt_c = count;
        if (load) begin
            count_nxt_c = load_val;
        end else if (count != '0) begin
            count_nxt_c = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt_c;
        end
    end

    assign tc_c = (count == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// Tile sequencer: kernel load, activation stream and OFIFO drain for the corelet.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned len_bw  = 6,
    parameter int unsigned addr_bw = 11
) (
    input logic            clk,
    input logic            reset,
    corelet_ctrl_if.master bus
);
    localparam int unsigned PH_MAX = ((row + col) > (1 << len_bw)) ? (row + col) : (1 << len_bw);
    localparam int unsigned CNT_W  = $clog2(PH_MAX + 1);

    state_t             state, state_nxt;
    logic               acc_q, acc_nxt;
    logic [len_bw-1:0]  len_q, len_nxt;
    logic [addr_bw-1:0] w_q, w_nxt, x_q, x_nxt, p_q, p_nxt;
    logic [len_bw-1:0]  rd_cnt, rd_cnt_nxt, rd_base;
    logic               rd_go;
    logic               load;
    logic [CNT_W-1:0]   load_val, cnt_nxt;
    logic               tc;

    logic [INST_W-1:0]  inst_q, inst_nxt;
    logic               xw_q, xw_nxt, sfp_q, sfp_nxt, busy_q, busy_nxt, done_q, done_nxt;

    phase_counter #(.WIDTH(CNT_W)) u_phase (
        .clk         (clk),
        .rst         (reset),
        .load        (load),
        .load_val    (load_val),
        .count_nxt_c (cnt_nxt),
        .tc_c        (tc)
    );

    // State register with the tile context latched on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            acc_q  <= 1'b0;
            len_q  <= '0;
            w_q    <= '0;
            x_q    <= '0;
            p_q    <= '0;
            rd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            acc_q  <= acc_nxt;
            len_q  <= len_nxt;
            w_q    <= w_nxt;
            x_q    <= x_nxt;
            p_q    <= p_nxt;
            rd_cnt <= rd_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_KWR;
            S_KWR:   if (tc) state_nxt = S_KLD;
            S_KLD:   if (tc) state_nxt = S_KWAIT;
            S_KWAIT: if (tc) state_nxt = (len_q == '0) ? S_DONE : S_XWR;
            S_XWR:   if (tc) state_nxt = S_EXEC;
            S_EXEC:  if (tc) state_nxt = S_DRAIN;
            S_DRAIN: if (tc) state_nxt = S_READ;
            // Stay until every read is issued and the last pmem write is on the bus.
            S_READ:  if ((rd_cnt == len_q) && !inst_q[OFIFO_RD]) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Context capture, OFIFO read accounting and phase length on every state entry.
    always_comb begin
        acc_nxt = acc_q;
        len_nxt = len_q;
        w_nxt   = w_q;
        x_nxt   = x_q;
        p_nxt   = p_q;
        if ((state == S_IDLE) && bus.start) begin
            acc_nxt = bus.acc;
            len_nxt = bus.len;
            w_nxt   = bus.w_base;
            x_nxt   = bus.x_base;
            p_nxt   = bus.p_base;
        end

        rd_base    = (state == S_READ) ? rd_cnt : '0;
        rd_go      = (state_nxt == S_READ) && bus.ofifo_valid && (rd_base < len_nxt);
        rd_cnt_nxt = (state_nxt == S_READ) ? (rd_base + len_bw'(rd_go)) : '0;

        load     = (state_nxt != state);
        load_val = '0;
        case (state_nxt)
            S_KWR:           load_val = CNT_W'(col);
            S_KLD:           load_val = CNT_W'(col - 1);
            S_KWAIT, S_DRAIN: load_val = CNT_W'(row + col - 1);
            S_XWR:           load_val = CNT_W'(len_nxt);
            S_EXEC:          load_val = CNT_W'(len_nxt) - CNT_W'(1);
            default:         load_val = '0;
        endcase
    end

    // Outputs for the coming cycle, decoded from the next state and counter value.
    always_comb begin
        inst_nxt           = INST_NOP;
        inst_nxt[ACC_ECHO] = acc_nxt;
        xw_nxt             = 1'b0;
        sfp_nxt            = 1'b0;
        busy_nxt           = 1'b1;
        done_nxt           = 1'b0;
        case (state_nxt)
            S_IDLE: begin
                inst_nxt = INST_IDLE;
                busy_nxt = 1'b0;
            end
            S_KWR: begin
                xw_nxt          = 1'b1;
                sfp_nxt         = (state == S_IDLE) && !acc_nxt;
                inst_nxt[L0_WR] = (cnt_nxt != CNT_W'(col));
                if (cnt_nxt != '0) begin
                    inst_nxt[XMEM_CEN] = 1'b0;
                    inst_nxt[XMEM_ADDR_MSB:XMEM_ADDR_LSB] =
                        w_nxt + addr_bw'(CNT_W'(col) - cnt_nxt);
                end
            end
            S_KLD: begin
                xw_nxt          = 1'b1;
                inst_nxt[KLOAD] = 1'b1;
                inst_nxt[L0_RD] = 1'b1;
            end
            S_XWR: begin
                inst_nxt[L0_WR] = (cnt_nxt != CNT_W'(len_nxt));
                if (cnt_nxt != '0) begin
                    inst_nxt[XMEM_CEN] = 1'b0;
                    inst_nxt[XMEM_ADDR_MSB:XMEM_ADDR_LSB] =
                        x_nxt + addr_bw'(CNT_W'(len_nxt) - cnt_nxt);
                end
            end
            S_EXEC: begin
                inst_nxt[EXEC]  = 1'b1;
                inst_nxt[L0_RD] = 1'b1;
            end
            S_READ: begin
                inst_nxt[OFIFO_RD] = rd_go;
                if (inst_q[OFIFO_RD]) begin
                    inst_nxt[PMEM_CEN] = 1'b0;
                    inst_nxt[PMEM_WEN] = 1'b0;
                    inst_nxt[PMEM_ADDR_MSB:PMEM_ADDR_LSB] =
                        p_nxt + addr_bw'(rd_cnt - len_bw'(1));
                end
            end
            S_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q <= INST_IDLE;
            xw_q   <= 1'b0;
            sfp_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            inst_q <= inst_nxt;
            xw_q   <= xw_nxt;
            sfp_q  <= sfp_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.inst      = inst_q;
    assign bus.xw_mode   = xw_q;
    assign bus.sfp_reset = sfp_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Cycle-exact check of corelet_ctrl against a phase-schedule model of a tile.
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [33:0] IDLE_W = 34'h1_8008_0000;

    typedef struct packed {
        logic [33:0] inst;
        logic        xw;
        logic        sfp;
        logic        busy;
        logic        done;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];
    bit   vpat[512];

    corelet_ctrl_if #(.len_bw(6), .addr_bw(11)) bus ();

    corelet_ctrl #(.row(ROW), .col(COL), .len_bw(6), .addr_bw(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] word(bit kl, bit ex, bit l0w, bit l0r, bit ofr,
                                         bit xrd, int xa, bit pwr, int pa, bit acc_e);
        logic [33:0] w;
        w        = '0;
        w[0]     = kl;
        w[1]     = ex;
        w[2]     = l0w;
        w[3]     = l0r;
        w[6]     = ofr;
        if (xrd) w[17:7] = 11'(xa);
        w[18]    = !xrd;
        w[19]    = 1'b1;
        if (pwr) w[30:20] = 11'(pa);
        w[31]    = !pwr;
        w[32]    = !pwr;
        w[33]    = acc_e;
        return w;
    endfunction

    // Expected per-cycle trace; index 0 is the cycle carrying start.
    function automatic void build(bit acc, int len, int wb, int xb, int pb);
        int  reads;
        int  pend;
        bit  rd;
        bit  wr;
        exp_q.delete();
        exp_q.push_back('{IDLE_W, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int k = 0; k <= COL; k++)
            exp_q.push_back('{word(0, 0, k > 0, 0, 0, k < COL, wb + k, 0, 0, acc),
                              1'b1, (k == 0) && !acc, 1'b1, 1'b0});
        for (int k = 0; k < COL; k++)
            exp_q.push_back('{word(1, 0, 0, 1, 0, 0, 0, 0, 0, acc), 1'b1, 1'b0, 1'b1, 1'b0});
        for (int k = 0; k < ROW + COL; k++)
            exp_q.push_back('{word(0, 0, 0, 0, 0, 0, 0, 0, 0, acc), 1'b0, 1'b0, 1'b1, 1'b0});
        if (len > 0) begin
            for (int k = 0; k <= len; k++)
                exp_q.push_back('{word(0, 0, k > 0, 0, 0, k < len, xb + k, 0, 0, acc),
                                  1'b0, 1'b0, 1'b1, 1'b0});
            for (int k = 0; k < len; k++)
                exp_q.push_back('{word(0, 1, 0, 1, 0, 0, 0, 0, 0, acc), 1'b0, 1'b0, 1'b1, 1'b0});
            for (int k = 0; k < ROW + COL; k++)
                exp_q.push_back('{word(0, 0, 0, 0, 0, 0, 0, 0, 0, acc), 1'b0, 1'b0, 1'b1, 1'b0});
            reads = 0;
            pend  = -1;
            for (int g = 0; g < 400; g++) begin
                rd = vpat[exp_q.size() - 1] && (reads < len);
                wr = (pend >= 0);
                exp_q.push_back('{word(0, 0, 0, 0, rd, 0, 0, wr, pb + pend, acc),
                                  1'b0, 1'b0, 1'b1, 1'b0});
                pend = rd ? reads : -1;
                if (rd) reads++;
                if ((reads == len) && (pend < 0)) break;
            end
        end
        exp_q.push_back('{word(0, 0, 0, 0, 0, 0, 0, 0, 0, acc), 1'b0, 1'b0, 1'b1, 1'b1});
        exp_q.push_back('{IDLE_W, 1'b0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{IDLE_W, 1'b0, 1'b0, 1'b0, 1'b0});
    endfunction

    // exp_done: cycle of the done pulse, -1 for none (abort), -2 to take it from the model.
    task automatic run_tile(input bit acc, input int len, input int wb, input int xb,
                            input int pb, input int poke_at, input int abort_at,
                            input int exp_done, input string tag);
        obs_t got;
        int   done_at;
        int   n_rd;
        int   want_done;
        build(acc, len, wb, xb, pb);
        want_done = exp_done;
        if (exp_done == -2) want_done = exp_q.size() - 3;
        done_at = -1;
        n_rd    = 0;
        for (int n = 0; n < exp_q.size(); n++) begin
            bus.start       = (n == 0) || (n == poke_at);
            bus.ofifo_valid = vpat[n];
            if (n == 0) begin
                bus.acc    = acc;
                bus.len    = 6'(len);
                bus.w_base = 11'(wb);
                bus.x_base = 11'(xb);
                bus.p_base = 11'(pb);
            end else begin
                bus.acc    = 1'($urandom_range(0, 1));
                bus.len    = 6'($urandom_range(0, 63));
                bus.w_base = 11'($urandom);
                bus.x_base = 11'($urandom);
                bus.p_base = 11'($urandom);
            end
            @(negedge clk);
            got = {bus.inst, bus.xw_mode, bus.sfp_reset, bus.busy, bus.done};
            tests++;
            assert (got === exp_q[n]) else begin
                fails++;
                $error("FAIL %s cyc %0d: got inst=%h xw/sfp/busy/done=%b%b%b%b, exp inst=%h xw/sfp/busy/done=%b%b%b%b",
                       tag, n, got.inst, got.xw, got.sfp, got.busy, got.done,
                       exp_q[n].inst, exp_q[n].xw, exp_q[n].sfp, exp_q[n].busy, exp_q[n].done);
            end
            if (bus.done) done_at = n;
            if (bus.inst[6]) n_rd++;
            if (n == abort_at) begin
                #2 reset = 1'b1;
                #1;
                tests++;
                assert (bus.inst === IDLE_W && bus.busy === 1'b0 && bus.done === 1'b0)
                else begin
                    fails++;
                    $error("FAIL %s async reset: got inst=%h busy=%b done=%b, exp inst=%h busy=0 done=0",
                           tag, bus.inst, bus.busy, bus.done, IDLE_W);
                end
                break;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        assert (done_at === want_done) else begin
            fails++;
            $error("FAIL %s done cycle: got %0d, exp %0d", tag, done_at, want_done);
        end
        if (abort_at < 0) begin
            tests++;
            assert (n_rd === len) else begin
                fails++;
                $error("FAIL %s ofifo reads: got %0d, exp %0d", tag, n_rd, len);
            end
        end
    endtask

    task automatic set_vpat_all(input bit v);
        for (int i = 0; i < 512; i++) vpat[i] = v;
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.acc         = 1'b0;
        bus.len         = '0;
        bus.w_base      = '0;
        bus.x_base      = '0;
        bus.p_base      = '0;
        bus.ofifo_valid = 1'b0;
        set_vpat_all(1'b1);

        #12;
        tests++;
        assert ({bus.inst, bus.xw_mode, bus.sfp_reset, bus.busy, bus.done} === {IDLE_W, 4'b0000})
        else begin
            fails++;
            $error("FAIL reset values: got inst=%h xw=%b sfp=%b busy=%b done=%b, exp inst=%h rest 0",
                   bus.inst, bus.xw_mode, bus.sfp_reset, bus.busy, bus.done, IDLE_W);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic tile.
        run_tile(1'b0, 4, 0, 16, 32, -1, -1, 64, "basic");

        // OFIFO valid 1,0,0,1,... from the cycle before READ: six stall cycles.
        for (int i = 0; i < 512; i++) vpat[i] = (i < 58) ? 1'b1 : (((i - 58) % 3) == 0);
        run_tile(1'b0, 4, 0, 16, 32, -1, -1, 70, "stall");
        set_vpat_all(1'b1);

        run_tile(1'b0, 0, 100, 200, 300, -1, -1, 34, "zero_len");

        run_tile(1'b1, 3, 2044, 2046, 2047, -1, -1, 61, "wrap_acc");

        // start during EXEC must be ignored.
        run_tile(1'b0, 4, 5, 40, 64, 40, -1, 64, "ignored_start");

        // Reset mid-XWR, then stay idle, then a fresh tile.
        run_tile(1'b0, 4, 0, 16, 32, -1, 36, -1, "abort");
        @(posedge clk);
        #1 reset = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            assert (bus.busy === 1'b0 && bus.done === 1'b0 && bus.inst === IDLE_W) else begin
                fails++;
                $error("FAIL post_abort idle %0d: got busy=%b done=%b inst=%h, exp busy=0 done=0 inst=%h",
                       i, bus.busy, bus.done, bus.inst, IDLE_W);
            end
            @(posedge clk);
            #1;
        end
        run_tile(1'b0, 4, 8, 24, 100, -1, -1, 64, "after_abort");

        // Randomized tiles with random OFIFO availability.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 512; i++) vpat[i] = 1'($urandom_range(0, 1));
            run_tile(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 2047)), -1, -1, -2, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
